// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
//
// Bundles every signal between the two writeback producers (execute path A,
// memory path B), the register-file write port and the arbiter itself.
//
//   master modport : producer / register-file side (drives requests,
//                    observes ready, the write bundle and occupancy)
//   slave  modport : wb_port_arbiter side
//
// Signals:
//   a_valid/a_ready/a_addr/a_data : execute-path write request handshake
//   b_valid/b_ready/b_addr/b_data : memory-path write request handshake
//   write_en/write_addr/write_data: registered register-file write
//   a_count/b_count               : queue occupancies
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;

    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;

    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  write_en, write_addr, write_data,
        input  a_count, b_count
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output write_en, write_addr, write_data,
        output a_count, b_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the execute path (A)
// and the memory path (B). Each path owns a small in-order FIFO behind a
// valid/ready handshake; a round-robin arbiter drains at most one entry per
// cycle into a registered write_en/write_addr/write_data bundle.
//
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : wb_port_arbiter_if.slave (request handshakes, write bundle,
//           queue occupancies)
//
// Entries addressed to register 0 are popped and consume their grant, but
// never raise write_en.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// wb_port_queue
//
// Circular in-order FIFO of {addr, data} used for each requester.
//
// Ports:
//   clk, reset            : clock / synchronous active-high reset
//   in_valid/in_ready     : push handshake (in_addr, in_data)
//   pop                   : remove the head entry (caller guarantees non-empty)
//   head_addr/head_data   : current head entry
//   not_empty, count      : occupancy
// ---------------------------------------------------------------------------
module wb_port_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       pop,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic                       not_empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push;

    // Ready looks only at the registered count: a full queue refuses a push
    // even in a cycle where it is also being popped.
    assign in_ready  = !reset && (count_q < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign not_empty = (count_q != '0);
    assign head_addr = addr_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];
    assign count     = count_q;

    // Pointers are exactly PW bits wide, so wrapping modulo DEPTH is free.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; push is already blocked while reset is high.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= in_addr;
            data_mem[wr_ptr_q] <= in_data;
        end
    end
endmodule

module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_port_arbiter_if.slave      bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } side_e;

    // Queue-side signals
    logic          a_ready, b_ready;
    logic          a_pop, b_pop;
    logic          a_not_empty, b_not_empty;
    logic [AW-1:0] a_head_addr, b_head_addr;
    logic [DW-1:0] a_head_data, b_head_data;
    logic [CW-1:0] a_count, b_count;

    // Arbiter state and registered write bundle
    side_e         last_grant_q, last_grant_d;
    logic          write_en_q,   write_en_d;
    logic [AW-1:0] write_addr_q, write_addr_d;
    logic [DW-1:0] write_data_q, write_data_d;

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          any_grant;

    wb_port_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_a_queue (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.a_valid),
        .in_ready  (a_ready),
        .in_addr   (bus.a_addr),
        .in_data   (bus.a_data),
        .pop       (a_pop),
        .head_addr (a_head_addr),
        .head_data (a_head_data),
        .not_empty (a_not_empty),
        .count     (a_count)
    );

    wb_port_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_b_queue (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.b_valid),
        .in_ready  (b_ready),
        .in_addr   (bus.b_addr),
        .in_data   (bus.b_data),
        .pop       (b_pop),
        .head_addr (b_head_addr),
        .head_data (b_head_data),
        .not_empty (b_not_empty),
        .count     (b_count)
    );

    // Round-robin grant: an uncontested side always wins; when both hold
    // entries the side that did not win last time is chosen. The grant pops
    // the queue on the same edge that registers the write bundle.
    always_comb begin
        a_pop        = a_not_empty && (!b_not_empty || (last_grant_q == GRANT_B));
        b_pop        = b_not_empty && (!a_not_empty || (last_grant_q == GRANT_A));
        any_grant    = a_pop || b_pop;
        sel_addr     = b_pop ? b_head_addr : a_head_addr;
        sel_data     = b_pop ? b_head_data : a_head_data;

        last_grant_d = last_grant_q;
        if (a_pop) begin
            last_grant_d = GRANT_A;
        end else if (b_pop) begin
            last_grant_d = GRANT_B;
        end

        // x0 writes are swallowed: the grant is used up but the port idles
        // and the previous address/data stay on the bus.
        write_en_d   = any_grant && (sel_addr != '0);
        write_addr_d = write_en_d ? sel_addr : write_addr_q;
        write_data_d = write_en_d ? sel_data : write_data_q;
    end

    // last_grant resets to B so that A wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_B;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign bus.a_ready    = a_ready;
    assign bus.b_ready    = b_ready;
    assign bus.a_count    = a_count;
    assign bus.b_count    = b_count;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed, table-driven bench for wb_port_arbiter (DEPTH=2, AW=5, DW=32).
// Each vector holds the inputs driven for one clock cycle and the outputs
// expected during that same cycle (registered outputs reflect earlier edges,
// ready reflects the current reset level).
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int BW    = 3 + AW + DW + 2 * CW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          rst;
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          ar;
        logic          br;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [CW-1:0] ac;
        logic [CW-1:0] bc;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input logic rst,
                                input logic av, input int aa, input int ad,
                                input logic bv, input int ba, input int bd,
                                input logic ar, input logic br, input logic we,
                                input int wa, input int wd,
                                input int ac, input int bc);
        vec_t v;
        v.rst = rst;
        v.av  = av;  v.aa = AW'(aa); v.ad = DW'(ad);
        v.bv  = bv;  v.ba = AW'(ba); v.bd = DW'(bd);
        v.ar  = ar;  v.br = br;      v.we = we;
        v.wa  = AW'(wa); v.wd = DW'(wd);
        v.ac  = CW'(ac); v.bc = CW'(bc);
        return v;
    endfunction

    // Drive one cycle of inputs after the edge, compare on the falling edge.
    task automatic apply(input vec_t v, input string name);
        logic [BW-1:0] act;
        logic [BW-1:0] exp;
        @(posedge clk);
        #1;
        reset       = v.rst;
        bus.a_valid = v.av;
        bus.a_addr  = v.aa;
        bus.a_data  = v.ad;
        bus.b_valid = v.bv;
        bus.b_addr  = v.ba;
        bus.b_data  = v.bd;
        @(negedge clk);
        act = {bus.a_ready, bus.b_ready, bus.write_en, bus.write_addr,
               bus.write_data, bus.a_count, bus.b_count};
        exp = {v.ar, v.br, v.we, v.wa, v.wd, v.ac, v.bc};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got ar=%0b br=%0b we=%0b wa=%0d wd=%h ac=%0d bc=%0d, want ar=%0b br=%0b we=%0b wa=%0d wd=%h ac=%0d bc=%0d",
                     name, bus.a_ready, bus.b_ready, bus.write_en, bus.write_addr,
                     bus.write_data, bus.a_count, bus.b_count,
                     v.ar, v.br, v.we, v.wa, v.wd, v.ac, v.bc);
        end
    endtask

    vec_t tbl[$];

    initial begin
        reset       = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
        repeat (2) @(posedge clk);

        //           rst av aa  ad       bv ba  bd     ar br we wa  wd       ac bc
        // Reset held with requests pending: nothing accepted or written.
        tbl.push_back(mk(1, 1, 9,  'h99,    1, 10, 'h10,  0, 0, 0, 0,  0,       0, 0));
        tbl.push_back(mk(1, 1, 9,  'h99,    1, 10, 'h10,  0, 0, 0, 0,  0,       0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 0,  0,       0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 0,  0,       0, 0));
        // Single A write: strobe two edges after acceptance, one cycle wide.
        tbl.push_back(mk(0, 1, 5,  'hAA,    0, 0,  0,     1, 1, 0, 0,  0,       0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 0,  0,       1, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 1, 5,  'hAA,    0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 5,  'hAA,    0, 0));
        // Reset restores last_grant=B and clears the write bundle.
        tbl.push_back(mk(1, 0, 0,  0,       0, 0,  0,     0, 0, 0, 5,  'hAA,    0, 0));
        // Contention right after reset: A first, then B.
        tbl.push_back(mk(0, 1, 3,  'h11,    1, 7,  'h22,  1, 1, 0, 0,  0,       0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 0,  0,       1, 1));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 1, 3,  'h11,    0, 1));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 1, 7,  'h22,    0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 7,  'h22,    0, 0));
        // Backpressure: A pushes 1,2,4 while B streams; refused offers repeat.
        tbl.push_back(mk(0, 1, 1,  'h1,     1, 20, 'hB0,  1, 1, 0, 7,  'h22,    0, 0));
        tbl.push_back(mk(0, 1, 2,  'h2,     1, 21, 'hB1,  1, 1, 0, 7,  'h22,    1, 1));
        tbl.push_back(mk(0, 1, 4,  'h4,     1, 22, 'hB2,  1, 0, 1, 1,  'h1,     1, 2));
        tbl.push_back(mk(0, 0, 0,  0,       1, 22, 'hB2,  0, 1, 1, 20, 'hB0,    2, 1));
        tbl.push_back(mk(0, 0, 0,  0,       1, 23, 'hB3,  1, 0, 1, 2,  'h2,     1, 2));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 1, 21, 'hB1,    1, 1));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 1, 4,  'h4,     0, 1));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 1, 22, 'hB2,    0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 22, 'hB2,    0, 0));
        // x0 suppression: dropped slot keeps the old address/data.
        tbl.push_back(mk(0, 1, 0,  'hDEAD,  0, 0,  0,     1, 1, 0, 22, 'hB2,    0, 0));
        tbl.push_back(mk(0, 1, 6,  'hBEEF,  0, 0,  0,     1, 1, 0, 22, 'hB2,    1, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 22, 'hB2,    1, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 1, 6,  'hBEEF,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0,  0,     1, 1, 0, 6,  'hBEEF,  0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset mid-stream with three entries queued (A: 24,25  B: 29) and a
        // write of 28 just issued; none of the queued entries may appear.
        apply(mk(0, 1, 24, 'hA24, 1, 28, 'hB28, 1, 1, 0, 6,  'hBEEF, 0, 0), "mid_fill0");
        apply(mk(0, 1, 25, 'hA25, 1, 29, 'hB29, 1, 1, 0, 6,  'hBEEF, 1, 1), "mid_fill1");
        apply(mk(1, 1, 26, 'hA26, 1, 30, 'hB30, 0, 0, 1, 28, 'hB28,  2, 1), "mid_reset");
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0),
                  $sformatf("mid_after%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port of the `writeback` stage between two producers: the execute (ALU result) path and the memory (load result) path. Each producer has a small in-order queue behind a valid/ready handshake. A round-robin arbiter drains at most one queued write per cycle into a registered `write_en`/`write_addr`/`write_data` bundle, which feeds the writeback stage's register-file write.

## Interface
- `DEPTH`, 2: entries per requester queue; power of two, ≥2
- `AW`, 5: register address width
- `DW`, 32: write data width
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `a_valid`  in  1  execute path has a write
- `a_ready`  out  1  execute queue can accept
- `a_addr`  in  AW  execute destination register
- `a_data`  in  DW  execute result
- `b_valid`  in  1  memory path has a write
- `b_ready`  out  1  memory queue can accept
- `b_addr`  in  AW  load destination register
- `b_data`  in  DW  load result
- `write_en`  out  1  register-file write strobe, one cycle per write
- `write_addr`  out  AW  register-file write address
- `write_data`  out  DW  register-file write data
- `a_count`  out  $clog2(DEPTH)+1  occupancy of the execute queue
- `b_count`  out  $clog2(DEPTH)+1  occupancy of the memory queue

## Operation
- Each queue is a circular FIFO with read pointer, write pointer, and count. Pointers wrap modulo DEPTH.
- Push: occurs when `x_valid & x_ready` at the clock edge. Pop: occurs when the arbiter grants that queue.
- Ready: `x_ready = !reset && (x_count < DEPTH)`. Ready does not depend on a same-cycle pop, so a full queue never accepts, even while it is being popped.
- Push and pop in the same cycle on a non-full, non-empty queue leave the count unchanged and both pointers advance.
- Arbiter state: `last_grant` (0 = A, 1 = B).
  - Only A non-empty: grant A.
  - Only B non-empty: grant B.
  - Both non-empty: grant the side opposite `last_grant`.
  - Both empty: no grant, and `last_grant` is unchanged.
  - Every grant sets `last_grant` to the granted side.
- Granted entry with addr ≠ 0: on the next edge, register `write_en=1`, `write_addr=addr`, `write_data=data`.
- Granted entry with addr = 0: the entry is popped and `last_grant` is updated, but `write_en=0`. `write_addr`/`write_data` hold their previous values. Register x0 is never written.
- No grant: `write_en=0`, and `write_addr`/`write_data` hold their values.
- Ordering:
  - Writes from one requester leave in acceptance order.
  - No ordering is enforced between A and B. Producers must not issue same-address writes on both ports with overlapping lifetimes.
- Sustained throughput is one write per cycle in total. With both queues continuously non-empty, grants alternate A, B, A, B.

## Timing
- Reset values:
  - `write_en=0`, `write_addr=0`, `write_data=0`
  - `a_count=b_count=0`, all pointers 0
  - `last_grant=1`, so A wins the first contested cycle
  - `a_ready=b_ready=0` while `reset` is high
- Pushes offered while `reset` is high are dropped.
- Reset mid-operation: all queued entries are discarded on that edge. `write_en` is 0 from the cycle after the reset edge.
- Latency: an entry pushed at edge E into an empty queue with no contention is granted in cycle E..E+1. `write_en` is high in the cycle after edge E+1, i.e. 2 edges from acceptance to a visible write strobe.
- Under contention, an entry waits at most one extra grant per older entry in its own queue, plus one interleaved grant from the other queue each.
- `write_en` is a single-cycle pulse per write. Back-to-back writes give `write_en` held high with new `write_addr`/`write_data` each cycle.
- Counts reflect the post-edge state. `x_ready` goes low in the cycle after the push that fills the queue.

## Test plan
- Reset: hold `reset` for 2 cycles with `a_valid=b_valid=1` -> `a_ready=b_ready=0`, `write_en=0`, counts 0. After release, no write caused by the requests held during reset.
- Single write: push A (addr 5, data 0x0000_00AA) -> `write_en=1`, `write_addr=5`, `write_data=0xAA` exactly 2 edges after acceptance; `write_en=0` the following cycle.
- Contention: push A (3, 0x11) and B (7, 0x22) in the same cycle after reset -> A's write appears first, B's write the next cycle, then `write_en=0`.
- Full/backpressure: with DEPTH=2, push 3 A writes (1/0x1, 2/0x2, 4/0x4) on consecutive cycles while B keeps its queue full -> `a_ready` drops at `a_count=2`. Writes drain alternating A/B, and A's order is 1, 2, 4.
- x0 suppression: push A (0, 0xDEAD) then A (6, 0xBEEF) -> no `write_en` for addr 0; `write_addr=6`, `write_data=0xBEEF` one cycle later. `write_addr` remains at its prior value during the dropped slot.
- Reset mid-stream: with both queues full, assert `reset` for one cycle -> `write_en=0` and counts 0 from the next cycle. None of the discarded entries are ever written.
